// File: rtl/bp_boot_rom_loader.sv
// Boot ROM loader: walks a combinational boot ROM and streams each word with its physical
// address over a valid/ready port. Optional XOR checksum: BP_BOOT_ROM_LOADER_CHECKSUM_EN.
module bp_boot_rom_loader #(
  parameter int unsigned boot_rom_width_p = 64,
  parameter int unsigned boot_rom_els_p   = 4,
  parameter int unsigned paddr_width_p    = 40,
  parameter logic [63:0] base_addr_p      = '0,
  localparam int unsigned rom_addr_width_lp = (boot_rom_els_p > 1) ? $clog2(boot_rom_els_p) : 1
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         start_i,
  output logic [rom_addr_width_lp-1:0] boot_rom_addr_o,
  input  logic [boot_rom_width_p-1:0]  boot_rom_data_i,
  output logic [paddr_width_p-1:0]     addr_o,
  output logic [boot_rom_width_p-1:0]  data_o,
  output logic                         v_o,
  input  logic                         ready_i,
  output logic                         busy_o,
  output logic                         done_o
`ifdef BP_BOOT_ROM_LOADER_CHECKSUM_EN
  ,
  output logic [boot_rom_width_p-1:0]  csum_o
`endif
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StSend  = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [rom_addr_width_lp-1:0] last_idx_lp =
      rom_addr_width_lp'(boot_rom_els_p - 1);
  localparam logic [paddr_width_p-1:0] base_lp   = paddr_width_p'(base_addr_p);
  localparam logic [paddr_width_p-1:0] stride_lp = paddr_width_p'(boot_rom_width_p / 8);

  logic [1:0]                   state_q, state_d;
  logic [rom_addr_width_lp-1:0] idx_q, idx_d;
  logic [paddr_width_p-1:0]     addr_q, addr_d;
  logic [boot_rom_width_p-1:0]  data_q, data_d;
  logic                         v_q, v_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;

  logic                         handshake;
  logic                         start_accept;
  logic [paddr_width_p-1:0]     word_addr;

  assign handshake    = v_q & ready_i;
  assign start_accept = start_i & ((state_q == StIdle) | (state_q == StDone));
  // Address wraps silently modulo 2^paddr_width_p.
  assign word_addr    = base_lp + paddr_width_p'(idx_q) * stride_lp;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    data_d  = data_q;
    v_d     = v_q;
    busy_d  = busy_q;
    done_d  = done_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_accept) begin
          state_d = StFetch;
          idx_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      StFetch: begin
        // ROM address settled last cycle, so the data port is valid now.
        data_d  = boot_rom_data_i;
        addr_d  = word_addr;
        v_d     = 1'b1;
        state_d = StSend;
      end
      StSend: begin
        if (handshake) begin
          v_d = 1'b0;
          if (idx_q == last_idx_lp) begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StFetch;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      idx_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      v_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      v_q     <= v_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign boot_rom_addr_o = idx_q;
  assign addr_o          = addr_q;
  assign data_o          = data_q;
  assign v_o             = v_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;

`ifdef BP_BOOT_ROM_LOADER_CHECKSUM_EN
  logic [boot_rom_width_p-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (start_accept) begin
      csum_d = '0;
    end else if (handshake) begin
      csum_d = csum_q ^ data_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign csum_o = csum_q;
`endif

  // A stalled word must stay put until the consumer takes it.
  hold_while_stalled: assert property (@(posedge clk_i) disable iff (reset_i)
      (v_q && !ready_i) |=> (v_q && $stable(addr_q) && $stable(data_q)));
  valid_implies_busy: assert property (@(posedge clk_i) disable iff (reset_i)
      v_q |-> busy_q);
  busy_done_exclusive: assert property (@(posedge clk_i) disable iff (reset_i)
      !(busy_q && done_q));

endmodule

// File: tb/tb_bp_boot_rom_loader.sv
// Scoreboard bench for bp_boot_rom_loader: directed passes push expected words into a queue,
// a negedge monitor pops and compares on every handshake.
module tb_bp_boot_rom_loader;

  typedef struct packed {
    logic [31:0] addr;
    logic [63:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // DUT 0: 4 x 64-bit words at 0x8000_0000
  logic        start0, ready0;
  logic [1:0]  rom_addr0;
  logic [63:0] rom_data0, data0;
  logic [31:0] addr0;
  logic        v0, busy0, done0;
  // DUT 1: 2 x 64-bit words at 0xFFFF_FFF8 (address wrap)
  logic        start1, ready1;
  logic [0:0]  rom_addr1;
  logic [63:0] rom_data1, data1;
  logic [31:0] addr1;
  logic        v1, busy1, done1;
`ifdef BP_BOOT_ROM_LOADER_CHECKSUM_EN
  logic [63:0] csum0, csum1;
`endif

  logic [63:0] rom0 [4] = '{64'hDEAD_BEEF_0000_0001, 64'h0123_4567_0000_0002,
                            64'hCAFE_F00D_0000_0004, 64'h0F0F_F0F0_0000_0008};
  logic [31:0] exp_addr0 [4] = '{32'h8000_0000, 32'h8000_0008, 32'h8000_0010, 32'h8000_0018};
  logic [63:0] rom1 [2] = '{64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
  logic [31:0] exp_addr1 [2] = '{32'hFFFF_FFF8, 32'h0000_0000};
  logic [63:0] exp_csum0 = 64'h1A7F_FB75_0000_000F;
  logic [63:0] exp_csum1 = 64'h4444_4444_4444_CCCC;

  assign rom_data0 = rom0[rom_addr0];
  assign rom_data1 = rom1[rom_addr1];

  bp_boot_rom_loader #(
    .boot_rom_width_p(64), .boot_rom_els_p(4), .paddr_width_p(32),
    .base_addr_p(64'h8000_0000)
  ) dut0 (
    .clk_i(clk), .reset_i(reset), .start_i(start0), .boot_rom_addr_o(rom_addr0),
    .boot_rom_data_i(rom_data0), .addr_o(addr0), .data_o(data0), .v_o(v0),
    .ready_i(ready0), .busy_o(busy0), .done_o(done0)
`ifdef BP_BOOT_ROM_LOADER_CHECKSUM_EN
    , .csum_o(csum0)
`endif
  );

  bp_boot_rom_loader #(
    .boot_rom_width_p(64), .boot_rom_els_p(2), .paddr_width_p(32),
    .base_addr_p(64'hFFFF_FFF8)
  ) dut1 (
    .clk_i(clk), .reset_i(reset), .start_i(start1), .boot_rom_addr_o(rom_addr1),
    .boot_rom_data_i(rom_data1), .addr_o(addr1), .data_o(data1), .v_o(v1),
    .ready_i(ready1), .busy_o(busy1), .done_o(done1)
`ifdef BP_BOOT_ROM_LOADER_CHECKSUM_EN
    , .csum_o(csum1)
`endif
  );

  int   n_vec = 0;
  int   n_err = 0;
  int   hs0 = 0;
  int   hs1 = 0;
  exp_t q0 [$];
  exp_t q1 [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_pass0();
    for (int k = 0; k < 4; k++) q0.push_back('{addr: exp_addr0[k], data: rom0[k]});
  endtask

  task automatic pulse_start0();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
  endtask

  task automatic wait_done0(input int limit);
    int n = 0;
    while (!done0 && n < limit) begin
      tick();
      n++;
    end
    check("done0_reached", 64'(done0), 64'd1);
  endtask

  // Monitor for DUT 0: scoreboard pop on handshake plus hold-while-stalled check.
  logic        prev_stall0 = 1'b0;
  logic        prev_rst0 = 1'b1;
  logic [31:0] prev_addr0;
  logic [63:0] prev_data0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset && prev_stall0 && !prev_rst0) begin
      check("hold_v0", 64'(v0), 64'd1);
      check("hold_addr0", 64'(addr0), 64'(prev_addr0));
      check("hold_data0", data0, prev_data0);
    end
    if (!reset && v0 && ready0) begin
      hs0++;
      n_vec++;
      if (q0.size() == 0) begin
        n_err++;
        $display("FAIL extra_word0: got addr %h data %h, expected no word", addr0, data0);
      end else begin
        e = q0.pop_front();
        n_vec--;
        check("word_addr0", 64'(addr0), 64'(e.addr));
        check("word_data0", data0, e.data);
      end
    end
    prev_stall0 = v0 && !ready0;
    prev_rst0   = reset;
    prev_addr0  = addr0;
    prev_data0  = data0;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset && v1 && ready1) begin
      hs1++;
      n_vec++;
      if (q1.size() == 0) begin
        n_err++;
        $display("FAIL extra_word1: got addr %h data %h, expected no word", addr1, data1);
      end else begin
        e = q1.pop_front();
        n_vec--;
        check("word_addr1", 64'(addr1), 64'(e.addr));
        check("word_data1", data1, e.data);
      end
    end
  end

  initial begin
    reset = 1'b1; start0 = 1'b0; ready0 = 1'b1; start1 = 1'b0; ready1 = 1'b1;
    tick(3);
    reset = 1'b0;
    check("rst_rom_addr0", 64'(rom_addr0), 64'd0);
    check("rst_addr0", 64'(addr0), 64'd0);
    check("rst_data0", data0, 64'd0);
    check("rst_v0", 64'(v0), 64'd0);
    check("rst_busy0", 64'(busy0), 64'd0);
    check("rst_done0", 64'(done0), 64'd0);
`ifdef BP_BOOT_ROM_LOADER_CHECKSUM_EN
    check("rst_csum0", csum0, 64'd0);
`endif

    // 1: streaming with ready high; done at cycle 9 after start at cycle 0
    hs0 = 0;
    push_pass0();
    pulse_start0();
    check("t1_busy_c1", 64'(busy0), 64'd1);
    check("t1_v_c1", 64'(v0), 64'd0);
    tick();
    check("t1_v_c2", 64'(v0), 64'd1);
    tick(6);
    check("t1_done_c8", 64'(done0), 64'd0);
    tick();
    check("t1_done_c9", 64'(done0), 64'd1);
    check("t1_busy_c9", 64'(busy0), 64'd0);
    check("t1_hs", 64'(hs0), 64'd4);
`ifdef BP_BOOT_ROM_LOADER_CHECKSUM_EN
    check("t1_csum", csum0, exp_csum0);
`endif

    // 2: stall word 1 for five cycles
    hs0 = 0;
    push_pass0();
    pulse_start0();
    tick(3);
    ready0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t2_stall_v", 64'(v0), 64'd1);
      check("t2_stall_addr", 64'(addr0), 64'(exp_addr0[1]));
      tick();
    end
    ready0 = 1'b1;
    wait_done0(40);
    check("t2_hs", 64'(hs0), 64'd4);
    check("t2_q_empty", 64'(q0.size()), 64'd0);

    // 3: start during SEND ignored, start in DONE replays
    hs0 = 0;
    push_pass0();
    pulse_start0();
    tick(5);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick(2);
    check("t3_done_c9", 64'(done0), 64'd1);
    check("t3_hs", 64'(hs0), 64'd4);
    hs0 = 0;
    push_pass0();
    pulse_start0();
    check("t3_restart_done", 64'(done0), 64'd0);
    check("t3_restart_busy", 64'(busy0), 64'd1);
    check("t3_restart_idx", 64'(rom_addr0), 64'd0);
    wait_done0(40);
    check("t3_replay_hs", 64'(hs0), 64'd4);
`ifdef BP_BOOT_ROM_LOADER_CHECKSUM_EN
    check("t3_csum", csum0, exp_csum0);
`endif

    // 4: reset while word 2 is presented
    hs0 = 0;
    push_pass0();
    pulse_start0();
    tick(5);
    check("t4_v_word2", 64'(v0), 64'd1);
    ready0 = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t4_v", 64'(v0), 64'd0);
    check("t4_busy", 64'(busy0), 64'd0);
    check("t4_done", 64'(done0), 64'd0);
    check("t4_rom_addr", 64'(rom_addr0), 64'd0);
    check("t4_hs_before", 64'(hs0), 64'd2);
    q0.delete();
    ready0 = 1'b1;
    hs0 = 0;
    push_pass0();
    pulse_start0();
    wait_done0(40);
    check("t4_fresh_hs", 64'(hs0), 64'd4);
`ifdef BP_BOOT_ROM_LOADER_CHECKSUM_EN
    check("t4_csum", csum0, exp_csum0);
`endif

    // 5: address wrap on a 2-word ROM; done at cycle 5
    hs1 = 0;
    for (int k = 0; k < 2; k++) q1.push_back('{addr: exp_addr1[k], data: rom1[k]});
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick(3);
    check("t5_done_c4", 64'(done1), 64'd0);
    tick();
    check("t5_done_c5", 64'(done1), 64'd1);
    check("t5_hs", 64'(hs1), 64'd2);
`ifdef BP_BOOT_ROM_LOADER_CHECKSUM_EN
    check("t5_csum", csum1, exp_csum1);
`endif

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
